// File: rtl/z_core_pkg.sv
// z_core shared ALU-op, opcode and funct constants.
// Used by the instruction encoder and the ALU-control decoder.
package z_core_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_BEQ  = 4'd10,
    ALU_BNE  = 4'd11,
    ALU_BLT  = 4'd12,
    ALU_BGE  = 4'd13,
    ALU_BLTU = 4'd14,
    ALU_BGEU = 4'd15
  } alu_op_e;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_B = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam int          ENT_W    = 33;

  function automatic logic [2:0] op_f3(alu_op_e op);
    unique case (op)
      ALU_ADD, ALU_SUB: return F3_ADD;
      ALU_SLL:          return F3_SLL;
      ALU_SLT:          return F3_SLT;
      ALU_SLTU:         return F3_SLTU;
      ALU_XOR:          return F3_XOR;
      ALU_SRL, ALU_SRA: return F3_SR;
      ALU_OR:           return F3_OR;
      ALU_AND:          return F3_AND;
      ALU_BEQ:          return F3_BEQ;
      ALU_BNE:          return F3_BNE;
      ALU_BLT:          return F3_BLT;
      ALU_BGE:          return F3_BGE;
      ALU_BLTU:         return F3_BLTU;
      ALU_BGEU:         return F3_BGEU;
      default:          return F3_ADD;
    endcase
  endfunction

endpackage

// File: rtl/z_core_inst_encoder_if.sv
// Request and instruction valid/ready bundle of the encoder.
// master: requester/consumer side; slave: encoder side.
interface z_core_inst_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic        req_use_imm;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [12:0] req_imm;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic        inst_err;
  logic        err_sticky;
  logic        err_clr;

  modport master (
    output req_valid, req_op, req_use_imm,
    output req_rd, req_rs1, req_rs2, req_imm,
    output inst_ready, err_clr,
    input  req_ready, inst_valid, inst_data,
    input  inst_err, err_sticky
  );

  modport slave (
    input  req_valid, req_op, req_use_imm,
    input  req_rd, req_rs1, req_rs2, req_imm,
    input  inst_ready, err_clr,
    output req_ready, inst_valid, inst_data,
    output inst_err, err_sticky
  );
endinterface

// File: rtl/z_core_inst_fifo.sv
// Registered valid/ready FIFO, power-of-two depth.
// No full-bypass: a full FIFO refuses pushes even while popping.
module z_core_inst_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop;

  assign in_ready_o  = cnt_q < CW'(DEPTH);
  assign out_valid_o = cnt_q != '0;
  assign out_data_o  = mem_q[rptr_q];
  assign push = in_valid_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      push && !pop: cnt_d = cnt_q + CW'(1);
      pop && !push: cnt_d = cnt_q - CW'(1);
      default:      cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        mem_q[wptr_q] <= in_data_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop)
        rptr_q <= rptr_q + AW'(1);
    end
  end
endmodule

// File: rtl/z_core_inst_encoder.sv
// ALU-op request to RV32I R/I/B word encoder with output FIFO.
// Z_CORE_ENC_CHECK_EN: illegal requests become NOP with err set.
import z_core_pkg::*;

module z_core_inst_encoder #(
  parameter int FIFO_DEPTH = 2
) (
  input logic clk,
  input logic rstn,
  z_core_inst_encoder_if.slave bus
);
  alu_op_e          op;
  logic             is_br, is_sh, use_i, illegal;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [31:0]      word;
  logic [ENT_W-1:0] ent, head;
  logic             push, err_q, err_d;
  logic [4:0]       rd, rs1, rs2;
  logic [12:0]      imm;

  assign rd  = bus.req_rd;
  assign rs1 = bus.req_rs1;
  assign rs2 = bus.req_rs2;
  assign imm = bus.req_imm;

  always_comb begin
    op    = alu_op_e'(bus.req_op);
    is_br = op >= ALU_BEQ;
    is_sh = op inside {ALU_SLL, ALU_SRL, ALU_SRA};
    use_i = bus.req_use_imm & ~is_br;
    f3    = op_f3(op);
    f7    = F7_BASE;
    if (op == ALU_SRA || (op == ALU_SUB && !use_i))
      f7 = F7_ALT;
    word = '0;
    unique case (1'b1)
      is_br:
        word = {imm[12], imm[10:5], rs2, rs1,
                f3, imm[4:1], imm[11], OPC_B};
      use_i && is_sh:
        word = {f7, imm[4:0], rs1, f3, rd, OPC_I};
      use_i && !is_sh:
        word = {imm[11:0], rs1, f3, rd, OPC_I};
      default:
        word = {f7, rs2, rs1, f3, rd, OPC_R};
    endcase
  end

`ifdef Z_CORE_ENC_CHECK_EN
  always_comb begin
    illegal = 1'b0;
    unique case (1'b1)
      is_br:          illegal = imm[0];
      use_i && is_sh: illegal = imm[12:5] != '0;
      use_i && !is_sh:
        illegal = (op == ALU_SUB) || (imm[12] != imm[11]);
      default:        illegal = 1'b0;
    endcase
  end
`else
  assign illegal = 1'b0;
`endif

  assign ent = illegal ? {1'b1, NOP_WORD} : {1'b0, word};

  z_core_inst_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid_i  (bus.req_valid),
    .in_ready_o  (bus.req_ready),
    .in_data_i   (ent),
    .out_valid_o (bus.inst_valid),
    .out_ready_i (bus.inst_ready),
    .out_data_o  (head)
  );

  assign bus.inst_data = head[31:0];
  assign bus.inst_err  = head[32];

  assign push  = bus.req_valid & bus.req_ready;
  // a new illegal accept beats a same-cycle clear
  assign err_d = (push & illegal) | (err_q & ~bus.err_clr);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign bus.err_sticky = err_q;
endmodule

// File: tb/tb_z_core_inst_encoder.sv
// Directed vector bench for z_core_inst_encoder.
// Expectations follow Z_CORE_ENC_CHECK_EN when it is defined.
module tb_z_core_inst_encoder;
  import z_core_pkg::*;

`ifdef Z_CORE_ENC_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  z_core_inst_encoder_if ifc ();

  z_core_inst_encoder #(.FIFO_DEPTH(2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifc.slave)
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic        ui;
    logic [4:0]  rd, rs1, rs2;
    logic [12:0] imm;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(
    string nm, logic [3:0] op, logic ui,
    logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
    logic [12:0] imm, logic [31:0] exp, logic err);
    vec_t v;
    v.name = nm; v.op = op; v.ui = ui;
    v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.exp = exp; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ifc.req_valid   = 1'b1;
    ifc.req_op      = v.op;
    ifc.req_use_imm = v.ui;
    ifc.req_rd      = v.rd;
    ifc.req_rs1     = v.rs1;
    ifc.req_rs2     = v.rs2;
    ifc.req_imm     = v.imm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ill(logic [31:0] w);
    return CHK ? NOP_WORD : w;
  endfunction

  vec_t v_add, v_sub, v_beq, v_addi, v_srai, v_subi;

  initial begin
    ifc.req_valid   = 1'b0;
    ifc.req_op      = '0;
    ifc.req_use_imm = 1'b0;
    ifc.req_rd      = '0;
    ifc.req_rs1     = '0;
    ifc.req_rs2     = '0;
    ifc.req_imm     = '0;
    ifc.inst_ready  = 1'b0;
    ifc.err_clr     = 1'b0;

    vq.push_back(mk("add",  0,0, 1,2,3, 13'h0AB, 32'h003100B3, 0));
    vq.push_back(mk("sub",  1,0, 3,4,5, 13'h000, 32'h405201B3, 0));
    vq.push_back(mk("sll",  2,0, 1,2,3, 13'h000, 32'h003110B3, 0));
    vq.push_back(mk("slt",  3,0, 1,2,3, 13'h000, 32'h003120B3, 0));
    vq.push_back(mk("sltu", 4,0, 1,2,3, 13'h000, 32'h003130B3, 0));
    vq.push_back(mk("xor",  5,0, 1,2,3, 13'h000, 32'h003140B3, 0));
    vq.push_back(mk("srl",  6,0, 1,2,3, 13'h000, 32'h003150B3, 0));
    vq.push_back(mk("sra",  7,0, 1,2,3, 13'h000, 32'h403150B3, 0));
    vq.push_back(mk("or",   8,0, 1,2,3, 13'h000, 32'h003160B3, 0));
    vq.push_back(mk("and",  9,0, 1,2,3, 13'h000, 32'h003170B3, 0));
    vq.push_back(mk("addi", 0,1, 1,0,31,13'h1FFF,32'hFFF00093, 0));
    vq.push_back(mk("addimin",0,1,1,0,0,13'h1800,32'h80000093, 0));
    vq.push_back(mk("slti", 3,1, 1,2,0, 13'h005, 32'h00512093, 0));
    vq.push_back(mk("andi", 9,1, 1,2,0, 13'h7FF, 32'h7FF17093, 0));
    vq.push_back(mk("srai", 7,1, 5,6,0, 13'h003, 32'h40335293, 0));
    vq.push_back(mk("slli", 2,1, 1,2,0, 13'h01F, 32'h01F11093, 0));
    vq.push_back(mk("srli", 6,1, 1,2,0, 13'h01F, 32'h01F15093, 0));
    vq.push_back(mk("beq", 10,1,31,1,2, 13'h008, 32'h00208463, 0));
    vq.push_back(mk("bne", 11,0, 0,1,2, 13'h1FFC,32'hFE209EE3, 0));
    vq.push_back(mk("blt", 12,0, 0,5,6, 13'h010, 32'h0062C863, 0));
    vq.push_back(mk("bge", 13,0, 0,1,2, 13'h008, 32'h0020D463, 0));
    vq.push_back(mk("bltu",14,0, 0,1,2, 13'h008, 32'h0020E463, 0));
    vq.push_back(mk("bgeu",15,0, 0,3,4, 13'h0FFE,32'h7E41FFE3, 0));
    vq.push_back(mk("subi", 1,1, 1,2,0, 13'h005,
                    ill(32'h00510093), CHK));
    vq.push_back(mk("sllibad",2,1,1,2,0,13'h020,
                    ill(32'h00011093), CHK));
    vq.push_back(mk("addiovf",0,1,1,2,0,13'h0800,
                    ill(32'h80010093), CHK));
    vq.push_back(mk("beqodd",10,0,0,1,2,13'h009,
                    ill(32'h00208463), CHK));

    v_add  = vq[0];
    v_sub  = vq[1];
    v_beq  = vq[17];
    v_addi = vq[10];
    v_srai = vq[14];
    v_subi = vq[23];

    // reset state
    #12;
    chk("rst_valid",  ifc.inst_valid, 0);
    chk("rst_data",   ifc.inst_data,  0);
    chk("rst_err",    ifc.inst_err,   0);
    chk("rst_sticky", ifc.err_sticky, 0);
    chk("rst_ready",  ifc.req_ready,  1);
    step();
    rstn = 1'b1;
    ifc.inst_ready = 1'b1;
    step();

    foreach (vq[i]) begin
      chk({vq[i].name, "_rdy"}, ifc.req_ready, 1);
      drive(vq[i]);
      step();
      ifc.req_valid = 1'b0;
      chk({vq[i].name, "_vld"}, ifc.inst_valid, 1);
      chk(vq[i].name, ifc.inst_data, vq[i].exp);
      chk({vq[i].name, "_err"}, ifc.inst_err, vq[i].err);
      step();
      chk({vq[i].name, "_pop"}, ifc.inst_valid, 0);
    end

    // sticky error: set, clear, set-beats-clear
    chk("sticky_set", ifc.err_sticky, CHK);
    ifc.err_clr = 1'b1;
    step();
    ifc.err_clr = 1'b0;
    chk("sticky_clr", ifc.err_sticky, 0);
    drive(v_subi);
    ifc.err_clr = 1'b1;
    step();
    ifc.req_valid = 1'b0;
    ifc.err_clr   = 1'b0;
    chk("sticky_win", ifc.err_sticky, CHK);
    step();
    ifc.err_clr = 1'b1;
    step();
    ifc.err_clr = 1'b0;

    // fill with consumer stalled
    ifc.inst_ready = 1'b0;
    drive(v_add);
    step();
    chk("f1_vld",  ifc.inst_valid, 1);
    chk("f1_data", ifc.inst_data,  v_add.exp);
    chk("f1_rdy",  ifc.req_ready,  1);
    drive(v_sub);
    step();
    ifc.req_valid = 1'b0;
    chk("f2_rdy",  ifc.req_ready, 0);
    chk("f2_data", ifc.inst_data, v_add.exp);
    step();
    chk("f3_rdy",  ifc.req_ready, 0);
    chk("f3_data", ifc.inst_data, v_add.exp);

    // pop while full: offered request must be refused
    drive(v_beq);
    ifc.inst_ready = 1'b1;
    step();
    ifc.inst_ready = 1'b0;
    chk("nb_data", ifc.inst_data, v_sub.exp);
    chk("nb_rdy",  ifc.req_ready, 1);

    // simultaneous push and pop at count 1
    ifc.inst_ready = 1'b1;
    step();
    ifc.req_valid  = 1'b0;
    ifc.inst_ready = 1'b0;
    chk("pp_data", ifc.inst_data,  v_beq.exp);
    chk("pp_vld",  ifc.inst_valid, 1);
    chk("pp_rdy",  ifc.req_ready,  1);
    drive(v_addi);
    step();
    ifc.req_valid = 1'b0;
    chk("pp_full", ifc.req_ready, 0);
    chk("pp_head", ifc.inst_data, v_beq.exp);
    ifc.inst_ready = 1'b1;
    step();
    ifc.inst_ready = 1'b0;
    chk("pp_next", ifc.inst_data, v_addi.exp);
    chk("pp_rdy2", ifc.req_ready, 1);
    drive(v_srai);
    step();
    ifc.req_valid = 1'b0;
    chk("pre_rst_rdy", ifc.req_ready, 0);

    // reset mid-stream flushes; handshake in reset cycle dropped
    rstn = 1'b0;
    #1;
    chk("mr_vld",  ifc.inst_valid, 0);
    chk("mr_rdy",  ifc.req_ready,  1);
    chk("mr_data", ifc.inst_data,  0);
    drive(v_add);
    ifc.inst_ready = 1'b1;
    step();
    rstn = 1'b1;
    ifc.req_valid = 1'b0;
    step();
    chk("mr_drop", ifc.inst_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
